// File: rtl/cpu_pipe_pkg.sv
// Shared ID/EX types: control bundle, its bubble value and perf counter type.
package cpu_pipe_pkg;

    localparam int unsigned REG_WORDS_DEF = 32;
    localparam int unsigned ADDR_W        = $clog2(REG_WORDS_DEF);
    localparam int unsigned ALU_OP_W      = 4;
    localparam int unsigned BYTE_EN_W     = 4;
    localparam int unsigned PERF_BITS_DEF = 16;

    // Control fields carried from ID into EX (halt is kept apart because it is sticky).
    typedef struct packed {
        logic                 atomic;
        logic                 sel_mem;
        logic                 check_link;
        logic                 mem_rw_;
        logic                 rw_;
        logic                 load_link_;
        logic                 alu_imm;
        logic [ADDR_W-1:0]    waddr;
        logic [ALU_OP_W-1:0]  alu_op;
        logic [BYTE_EN_W-1:0] byte_en;
    } id_ex_ctl_t;

    // Inactive control set: no register write, no memory write, no link.
    localparam id_ex_ctl_t ID_EX_BUBBLE = '{
        atomic:     1'b0,
        sel_mem:    1'b0,
        check_link: 1'b0,
        mem_rw_:    1'b1,
        rw_:        1'b1,
        load_link_: 1'b1,
        alu_imm:    1'b0,
        waddr:      '0,
        alu_op:     '0,
        byte_en:    '0
    };

    typedef logic [PERF_BITS_DEF-1:0] perf_cnt_t;

endpackage

// File: rtl/pipe_id_ex_hz_if.sv
// ID -> EX stage bundle: ID-side fields in, EX-side registered copies out.
interface pipe_id_ex_hz_if #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned SHIFT_BITS = 5
) ();

    localparam int unsigned AW  = cpu_pipe_pkg::ADDR_W;
    localparam int unsigned OPW = cpu_pipe_pkg::ALU_OP_W;
    localparam int unsigned BEW = cpu_pipe_pkg::BYTE_EN_W;

    // ID side
    logic                  valid_s2, stall_ex, flush;
    logic [AW-1:0]         rs_addr, rt_addr, waddr;
    logic                  uses_rs, uses_rt;
    logic                  atomic, sel_mem, check_link, mem_rw_, rw_, load_link_, alu_imm, halt_s2;
    logic [BITS-1:0]       r1_data, r2_data, sign_ext_imm;
    logic [SHIFT_BITS-1:0] shamt;
    logic [OPW-1:0]        alu_op;
    logic [BEW-1:0]        byte_en;

    // EX side
    logic                  valid_s3;
    logic                  atomic_s3, sel_mem_s3, check_link_s3, mem_rw_s3, rw_s3, load_link_s3, alu_imm_s3, halt_s3;
    logic [AW-1:0]         waddr_s3;
    logic [BITS-1:0]       r1_data_s3, r2_data_s3, sign_ext_imm_s3;
    logic [SHIFT_BITS-1:0] shamt_s3;
    logic [OPW-1:0]        alu_op_s3;
    logic [BEW-1:0]        byte_en_s3;
    logic                  stall_up;

    modport master (
        output valid_s2, stall_ex, flush, rs_addr, rt_addr, waddr, uses_rs, uses_rt,
               atomic, sel_mem, check_link, mem_rw_, rw_, load_link_, alu_imm, halt_s2,
               r1_data, r2_data, sign_ext_imm, shamt, alu_op, byte_en,
        input  valid_s3, atomic_s3, sel_mem_s3, check_link_s3, mem_rw_s3, rw_s3, load_link_s3,
               alu_imm_s3, halt_s3, waddr_s3, r1_data_s3, r2_data_s3, sign_ext_imm_s3,
               shamt_s3, alu_op_s3, byte_en_s3, stall_up
    );

    modport slave (
        input  valid_s2, stall_ex, flush, rs_addr, rt_addr, waddr, uses_rs, uses_rt,
               atomic, sel_mem, check_link, mem_rw_, rw_, load_link_, alu_imm, halt_s2,
               r1_data, r2_data, sign_ext_imm, shamt, alu_op, byte_en,
        output valid_s3, atomic_s3, sel_mem_s3, check_link_s3, mem_rw_s3, rw_s3, load_link_s3,
               alu_imm_s3, halt_s3, waddr_s3, r1_data_s3, r2_data_s3, sign_ext_imm_s3,
               shamt_s3, alu_op_s3, byte_en_s3, stall_up
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all-ones.
    always_ff @(posedge clk) begin
        if (!clr_) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_id_ex_hz.sv
// ID/EX pipeline register with valid bit, stall hold, flush, load-use bubble and perf counters.
module pipe_id_ex_hz
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned BITS         = 32,
    parameter int unsigned REG_WORDS    = 32,
    parameter int unsigned ADDR_LEFT    = $clog2(REG_WORDS) - 1,
    parameter int unsigned SHIFT_BITS   = 5,
    parameter int unsigned ALU_OP_PARAM = 3,
    parameter int unsigned PERF_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_,
    pipe_id_ex_hz_if.slave       bus,
    output logic [PERF_BITS-1:0] bubble_cnt,
    output logic [PERF_BITS-1:0] stall_cnt
);

    id_ex_ctl_t            ctl_q, ctl_in_c;
    logic                  valid_q, halt_q;
    logic [BITS-1:0]       r1_q, r2_q, imm_q;
    logic [SHIFT_BITS-1:0] shamt_q;
    logic [ADDR_LEFT:0]    rs_c, rt_c, wa_in_c, wa_s3_c;
    logic [ALU_OP_PARAM:0] alu_op_in_c;
    logic                  take_c, hazard_c, bubble_c, bubble_inc_c;

    assign rs_c        = bus.rs_addr;
    assign rt_c        = bus.rt_addr;
    assign wa_in_c     = bus.waddr;
    assign wa_s3_c     = ctl_q.waddr;
    assign alu_op_in_c = bus.alu_op;

    // A real instruction enters EX only while no halt is parked there.
    assign take_c = bus.valid_s2 & ~halt_q;

    // Load in EX whose destination is read by the instruction in ID.
    assign hazard_c = valid_q & ctl_q.sel_mem & ctl_q.mem_rw_ & ~ctl_q.rw_ & (wa_s3_c != '0)
                    & ((bus.uses_rs & (rs_c == wa_s3_c)) | (bus.uses_rt & (rt_c == wa_s3_c)))
                    & bus.valid_s2;

    assign bus.stall_up = bus.stall_ex | hazard_c;

    // Flush wins over hazard, stall_ex wins over both.
    assign bubble_c     = ~bus.stall_ex & (bus.flush | hazard_c);
    assign bubble_inc_c = bubble_c;

    // Control bundle to capture: ID controls for a live instruction, else inactive.
    always_comb begin
        ctl_in_c = ID_EX_BUBBLE;
        if (take_c) begin
            ctl_in_c.atomic     = bus.atomic;
            ctl_in_c.sel_mem    = bus.sel_mem;
            ctl_in_c.check_link = bus.check_link;
            ctl_in_c.mem_rw_    = bus.mem_rw_;
            ctl_in_c.rw_        = bus.rw_;
            ctl_in_c.load_link_ = bus.load_link_;
            ctl_in_c.alu_imm    = bus.alu_imm;
            ctl_in_c.waddr      = wa_in_c;
            ctl_in_c.alu_op     = alu_op_in_c;
            ctl_in_c.byte_en    = bus.byte_en;
        end
    end

    // Stage register: reset, bubble, hold on stall_ex, or capture.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            ctl_q   <= ID_EX_BUBBLE;
            r1_q    <= '0;
            r2_q    <= '0;
            imm_q   <= '0;
            shamt_q <= '0;
        end else if (bubble_c) begin
            valid_q <= 1'b0;
            ctl_q   <= ID_EX_BUBBLE;
            r1_q    <= '0;
            r2_q    <= '0;
            imm_q   <= '0;
            shamt_q <= '0;
        end else if (!bus.stall_ex) begin
            valid_q <= take_c;
            halt_q  <= halt_q | (take_c & bus.halt_s2);
            ctl_q   <= ctl_in_c;
            r1_q    <= bus.r1_data;
            r2_q    <= bus.r2_data;
            imm_q   <= bus.sign_ext_imm;
            shamt_q <= bus.shamt;
        end
    end

    assign bus.valid_s3        = valid_q;
    assign bus.atomic_s3       = ctl_q.atomic;
    assign bus.sel_mem_s3      = ctl_q.sel_mem;
    assign bus.check_link_s3   = ctl_q.check_link;
    assign bus.mem_rw_s3       = ctl_q.mem_rw_;
    assign bus.rw_s3           = ctl_q.rw_;
    assign bus.load_link_s3    = ctl_q.load_link_;
    assign bus.alu_imm_s3      = ctl_q.alu_imm;
    assign bus.halt_s3         = halt_q;
    assign bus.waddr_s3        = ctl_q.waddr;
    assign bus.alu_op_s3       = ctl_q.alu_op;
    assign bus.byte_en_s3      = ctl_q.byte_en;
    assign bus.r1_data_s3      = r1_q;
    assign bus.r2_data_s3      = r2_q;
    assign bus.sign_ext_imm_s3 = imm_q;
    assign bus.shamt_s3        = shamt_q;

    sat_counter #(.W(PERF_BITS)) u_bubble_cnt (
        .clk  (clk),
        .clr_ (rst_),
        .inc  (bubble_inc_c),
        .cnt  (bubble_cnt)
    );

    sat_counter #(.W(PERF_BITS)) u_stall_cnt (
        .clk  (clk),
        .clr_ (rst_),
        .inc  (bus.stall_ex),
        .cnt  (stall_cnt)
    );

endmodule
